ssb_seq_gen: RTL and testbench

Transmit-side generator of the NR synchronisation sequences. It produces the 127-sample BPSK PSS for N_id_2, then the 127-sample BPSK SSS for (N_id_1, N_id_2), as an AXI-stream of complex baseband subcarrier values. It feeds the test-signal/transmit path (subcarrier mapper → IFFT) and is the encoder counterpart of the receive chain's PSS correlator and SSS detector.

---
 rtl/ssb_seq_pkg.sv | 40 ++++
 rtl/ssb_seq_gen_mod127_counter.sv | 39 +++
 rtl/ssb_seq_gen.sv | 185 ++++++++++++++++++
 tb/tb_ssb_seq_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ssb_seq_pkg.sv
// ssb_seq_pkg
// Shared definitions for the NR PSS/SSS transmit sequence generator:
// sequence lengths and index limits, the FSM state enum, the latched
// request record, and the three 127-bit m-sequences (bit i = x(i)).
package ssb_seq_pkg;

   localparam int SEQ_LEN    = 127;
   localparam int N_id_1_MAX = 335;
   localparam int N_id_2_MAX = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PSS  = 2'd2,
      SSS  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [8:0] n_id_1;
      logic [1:0] n_id_2;
   } ssb_req_t;

   // Unrolls x(i+7) = x(i+tap) ^ x(i) from a 7-bit seed into the full
   // 127-entry sequence. Evaluated at elaboration only.
   function automatic logic [SEQ_LEN-1:0] lfsr_seq(input logic [6:0] seed,
                                                   input int tap);
      logic [SEQ_LEN-1:0] x;
      x      = '0;
      x[6:0] = seed;
      for (int i = 0; i < SEQ_LEN - 7; i++)
         x[i+7] = x[i+tap] ^ x[i];
      return x;
   endfunction

   // Seeds are written x(6)..x(0).
   localparam logic [SEQ_LEN-1:0] PSS_X  = lfsr_seq(7'b1110110, 4);
   localparam logic [SEQ_LEN-1:0] SSS_X0 = lfsr_seq(7'b0000001, 4);
   localparam logic [SEQ_LEN-1:0] SSS_X1 = lfsr_seq(7'b0000001, 1);

endpackage

// File: rtl/ssb_seq_gen_mod127_counter.sv
// mod127_counter
// Running index into a 127-entry sequence. Presets on load_i, advances on
// en_i, wraps 126 -> 0. Exposes the value the register takes at the next
// edge so the caller can fetch the matching sample into its own output
// register in the same cycle.
// Ports:
//   clk_i, reset_ni   clock, async active-low reset
//   load_i, preset_i  load preset value (wins over en_i)
//   en_i              advance by one
//   nxt_o             next-state index
module mod127_counter
   import ssb_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       load_i,
   input  logic [6:0] preset_i,
   input  logic       en_i,
   output logic [6:0] nxt_o
);

   logic [6:0] cnt_q;

   always_comb begin
      nxt_o = cnt_q;
      if (load_i)
         nxt_o = preset_i;
      else if (en_i)
         nxt_o = (cnt_q == 7'(SEQ_LEN - 1)) ? 7'd0 : cnt_q + 7'd1;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)
         cnt_q <= '0;
      else
         cnt_q <= nxt_o;
   end

endmodule

// File: rtl/ssb_seq_gen.sv
// ssb_seq_gen
// Generates the 127-sample BPSK PSS for N_id_2 followed by the 127-sample
// BPSK SSS for (N_id_1, N_id_2) as an AXI-stream of complex samples.
// Bit b maps to real = b ? -AMP : +AMP, imag = 0.
// Ports:
//   clk_i, reset_ni          clock, async active-low reset
//   N_id_1_i, N_id_2_i       cell id parts, sampled with N_id_valid_i in IDLE
//   N_id_valid_i             request strobe
//   busy_o                   request accepted, stream not yet finished
//   error_o                  one-cycle pulse on an out-of-range request
//   m_axis_out_*             sample stream; tuser 0 = PSS, 1 = SSS;
//                            tlast on the final SSS sample
module ssb_seq_gen
   import ssb_seq_pkg::*;
#(
   parameter int OUT_DW = 32,
   parameter int AMP    = 2**(OUT_DW/2-2)
)(
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [8:0]        N_id_1_i,
   input  logic [1:0]        N_id_2_i,
   input  logic              N_id_valid_i,
   output logic              busy_o,
   output logic              error_o,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tuser,
   output logic              m_axis_out_tlast,
   output logic              m_axis_out_tvalid,
   input  logic              m_axis_out_tready
);

   localparam int HW = OUT_DW / 2;
   localparam logic signed [HW-1:0] AMP_POS = HW'(AMP);
   localparam logic signed [HW-1:0] AMP_NEG = -AMP_POS;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LOAD = LOAD;
   localparam logic [1:0] S_PSS  = PSS;
   localparam logic [1:0] S_SSS  = SSS;

   localparam logic [6:0] LAST_N = 7'(SEQ_LEN - 1);

   function automatic logic [OUT_DW-1:0] bpsk(input logic b);
      return {{HW{1'b0}}, (b ? AMP_NEG : AMP_POS)};
   endfunction

   logic [1:0]  state_q;
   ssb_req_t    req_q;
   logic [6:0]  n_q;          // sample number within the current sequence
   logic        tvalid_q, tuser_q, tlast_q, err_q;
   logic [OUT_DW-1:0] tdata_q;

   logic        hs, legal, load;
   logic [1:0]  grp;
   logic [6:0]  pss_off, m0, m1;
   logic [6:0]  pss_nxt, x0_nxt, x1_nxt;

   assign hs    = tvalid_q & m_axis_out_tready;
   assign load  = (state_q == S_LOAD);
   assign legal = (N_id_1_i <= 9'(N_id_1_MAX)) && (N_id_2_i <= 2'(N_id_2_MAX));

   // Offsets from the latched request. The group floor(N_id_1/112) comes
   // from two compares; every offset lands in 0..111 so no mod is needed.
   always_comb begin
      grp = 2'd0;
      m0  = 7'd0;
      m1  = 7'(req_q.n_id_1);
      if (req_q.n_id_1 >= 9'd224) begin
         grp = 2'd2;
         m1  = 7'(req_q.n_id_1 - 9'd224);
      end else if (req_q.n_id_1 >= 9'd112) begin
         grp = 2'd1;
         m1  = 7'(req_q.n_id_1 - 9'd112);
      end
      case (grp)
         2'd1:    m0 = 7'd15;
         2'd2:    m0 = 7'd30;
         default: m0 = 7'd0;
      endcase
      m0 = m0 + 7'(req_q.n_id_2) * 7'd5;
      case (req_q.n_id_2)
         2'd1:    pss_off = 7'd43;
         2'd2:    pss_off = 7'd86;
         default: pss_off = 7'd0;
      endcase
   end

   // x0/x1 only advance during SSS, so at the PSS->SSS switch they still
   // sit on their presets and supply SSS n=0 without a bubble.
   mod127_counter u_pss_idx (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .load_i   (load),
      .preset_i (pss_off),
      .en_i     (hs && (state_q == S_PSS)),
      .nxt_o    (pss_nxt)
   );

   mod127_counter u_x0_idx (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .load_i   (load),
      .preset_i (m0),
      .en_i     (hs && (state_q == S_SSS)),
      .nxt_o    (x0_nxt)
   );

   mod127_counter u_x1_idx (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .load_i   (load),
      .preset_i (m1),
      .en_i     (hs && (state_q == S_SSS)),
      .nxt_o    (x1_nxt)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= S_IDLE;
         req_q    <= '0;
         n_q      <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= (state_q == S_IDLE) && N_id_valid_i && !legal;
         case (state_q)
            S_IDLE: begin
               if (N_id_valid_i && legal) begin
                  req_q   <= '{n_id_1: N_id_1_i, n_id_2: N_id_2_i};
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               state_q  <= S_PSS;
               n_q      <= '0;
               tvalid_q <= 1'b1;
               tuser_q  <= 1'b0;
               tlast_q  <= 1'b0;
               tdata_q  <= bpsk(PSS_X[pss_nxt]);
            end
            S_PSS: begin
               if (hs) begin
                  if (n_q == LAST_N) begin
                     state_q <= S_SSS;
                     n_q     <= '0;
                     tuser_q <= 1'b1;
                     tdata_q <= bpsk(SSS_X0[x0_nxt] ^ SSS_X1[x1_nxt]);
                  end else begin
                     n_q     <= n_q + 7'd1;
                     tdata_q <= bpsk(PSS_X[pss_nxt]);
                  end
               end
            end
            S_SSS: begin
               if (hs) begin
                  if (n_q == LAST_N) begin
                     state_q  <= S_IDLE;
                     tvalid_q <= 1'b0;
                     tuser_q  <= 1'b0;
                     tlast_q  <= 1'b0;
                     tdata_q  <= '0;
                  end else begin
                     n_q     <= n_q + 7'd1;
                     tlast_q <= (n_q == LAST_N - 7'd1);
                     tdata_q <= bpsk(SSS_X0[x0_nxt] ^ SSS_X1[x1_nxt]);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o            = (state_q != S_IDLE);
   assign error_o           = err_q;
   assign m_axis_out_tdata  = tdata_q;
   assign m_axis_out_tuser  = tuser_q;
   assign m_axis_out_tlast  = tlast_q;
   assign m_axis_out_tvalid = tvalid_q;

endmodule

// File: tb/tb_ssb_seq_gen.sv
// tb_ssb_seq_gen
// Directed bench for ssb_seq_gen: reset state, hand-computed first samples,
// full sequences against an independent model, stalls, illegal requests,
// mid-stream reset and back-to-back requests.
module tb_ssb_seq_gen;

   localparam logic [31:0] POS = 32'h0000_4000;
   localparam logic [31:0] NEG = 32'h0000_C000;

   logic        clk;
   logic        reset_ni;
   logic [8:0]  N_id_1;
   logic [1:0]  N_id_2;
   logic        N_id_valid;
   logic        busy, error;
   logic [31:0] tdata;
   logic        tuser, tlast, tvalid, tready;

   int checks = 0;
   int errors = 0;

   bit          pss_x [127];
   bit          x0b   [127];
   bit          x1b   [127];
   logic [31:0] rx    [254];

   ssb_seq_gen #(.OUT_DW(32)) dut (
      .clk_i             (clk),
      .reset_ni          (reset_ni),
      .N_id_1_i          (N_id_1),
      .N_id_2_i          (N_id_2),
      .N_id_valid_i      (N_id_valid),
      .busy_o            (busy),
      .error_o           (error),
      .m_axis_out_tdata  (tdata),
      .m_axis_out_tuser  (tuser),
      .m_axis_out_tlast  (tlast),
      .m_axis_out_tvalid (tvalid),
      .m_axis_out_tready (tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gold(input bit sss, input int n, input int n1, input int n2);
      bit b;
      int m0, m1;
      if (!sss)
         b = pss_x[(n + 43*n2) % 127];
      else begin
         m0 = 15*(n1/112) + 5*n2;
         m1 = n1 % 112;
         b  = x0b[(n + m0) % 127] ^ x1b[(n + m1) % 127];
      end
      return b ? NEG : POS;
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_tvalid"}, tvalid, 0);
      chk({tag, "_tdata"},  tdata,  0);
      chk({tag, "_tuser"},  tuser,  0);
      chk({tag, "_tlast"},  tlast,  0);
      chk({tag, "_busy"},   busy,   0);
      chk({tag, "_error"},  error,  0);
   endtask

   // Issues one request from IDLE and consumes stop_at beats.
   task automatic run(input int n1, input int n2, input int rdy_pct,
                      input int stop_at, input bit poke);
      int beat, cyc, n;
      bit stalled, sss;
      logic [31:0] held_d;
      logic held_u, held_l;
      N_id_1 = 9'(n1); N_id_2 = 2'(n2); N_id_valid = 1'b1;
      step;
      N_id_valid = 1'b0;
      chk("accept_busy",   busy,   1);
      chk("load_tvalid",   tvalid, 0);
      step;
      chk("first_tvalid",  tvalid, 1);
      beat = 0; cyc = 0; stalled = 0;
      held_d = '0; held_u = 0; held_l = 0;
      while (beat < stop_at && cyc < 3000) begin
         if (stalled) begin
            chk("stall_tdata", tdata, held_d);
            chk("stall_tuser", tuser, held_u);
            chk("stall_tlast", tlast, held_l);
         end
         chk("run_tvalid", tvalid, 1);
         chk("run_busy",   busy,   1);
         chk("run_error",  error,  0);
         tready = ($urandom_range(99) < rdy_pct);
         if (poke) begin
            N_id_1 = 9'd5; N_id_2 = 2'd1;
            N_id_valid = (beat == 50);
         end
         if (tvalid && tready) begin
            sss = (beat >= 127);
            n   = sss ? beat - 127 : beat;
            chk("tdata", tdata, gold(sss, n, n1, n2));
            chk("tuser", tuser, sss);
            chk("tlast", tlast, beat == 253);
            rx[beat] = tdata;
            beat++;
            stalled = 0;
         end else begin
            stalled = tvalid;
            held_d = tdata; held_u = tuser; held_l = tlast;
         end
         step;
         cyc++;
      end
      N_id_valid = 1'b0;
      tready = 1'b1;
      if (cyc >= 3000)
         chk("timeout_beats", beat, stop_at);
      if (stop_at == 254) begin
         chk("end_busy",   busy,   0);
         chk("end_tvalid", tvalid, 0);
         chk("end_tlast",  tlast,  0);
         if (rdy_pct == 100)
            chk("end_cycles", cyc, 254);
      end
   endtask

   task automatic bad(input int n1, input int n2);
      N_id_1 = 9'(n1); N_id_2 = 2'(n2); N_id_valid = 1'b1;
      step;
      N_id_valid = 1'b0;
      chk("bad_error_hi", error,  1);
      chk("bad_busy",     busy,   0);
      chk("bad_tvalid",   tvalid, 0);
      step;
      chk("bad_error_lo", error,  0);
      chk("bad_busy2",    busy,   0);
      chk("bad_tvalid2",  tvalid, 0);
   endtask

   initial begin
      int n1_list [6];
      logic [6:0] pss_hand;
      n1_list = '{0, 111, 112, 223, 224, 335};
      pss_hand = 7'b1110110;  // bit n set -> sample n is -AMP

      // Golden m-sequences from their recurrences.
      foreach (pss_x[i]) begin pss_x[i] = 0; x0b[i] = 0; x1b[i] = 0; end
      pss_x[1] = 1; pss_x[2] = 1; pss_x[4] = 1; pss_x[5] = 1; pss_x[6] = 1;
      x0b[0] = 1; x1b[0] = 1;
      for (int i = 0; i < 120; i++) begin
         pss_x[i+7] = pss_x[i+4] ^ pss_x[i];
         x0b[i+7]   = x0b[i+4]   ^ x0b[i];
         x1b[i+7]   = x1b[i+1]   ^ x1b[i];
      end

      reset_ni = 1'b0; N_id_1 = '0; N_id_2 = '0; N_id_valid = 1'b0; tready = 1'b1;
      #1;
      check_zero_outputs("reset");
      repeat (2) step;
      reset_ni = 1'b1;
      step;
      check_zero_outputs("idle");

      // Basic sequence with hand-computed leading samples.
      run(0, 0, 100, 254, 0);
      for (int n = 0; n < 7; n++)
         chk("pss_hand", rx[n], pss_hand[n] ? NEG : POS);
      for (int n = 0; n < 9; n++)
         chk("sss_hand", rx[127+n], POS);

      // Back-to-back: requested in the first cycle busy is low.
      run(0, 1, 100, 254, 0);

      // Offset boundaries for every N_id_2.
      for (int n2 = 0; n2 < 3; n2++)
         foreach (n1_list[i])
            run(n1_list[i], n2, 100, 254, 0);

      // Random back-pressure plus an ignored request mid-stream.
      run(200, 2, 50, 254, 1);
      step;
      chk("poke_no_restart_busy", busy, 0);

      // Illegal requests.
      bad(336, 0);
      bad(0, 3);
      bad(511, 3);

      // Reset while PSS n=60 is on the bus.
      run(100, 1, 100, 60, 0);
      chk("pre_reset_tvalid", tvalid, 1);
      #2 reset_ni = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      repeat (2) step;
      #2 reset_ni = 1'b1;
      step;
      check_zero_outputs("post_reset");
      run(100, 1, 100, 254, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
